// File: rtl/apf_pkg.sv
// ---------------------------------------------------------------------------
// apf_pkg
//
// Purpose
//   Shared definitions for the cartridge loader: the loader state enum and
//   the byte pattern written into cartridge RAM while it is being cleared.
//
// Contents
//   loader_state_t : IDLE / CLEAR / LOAD / DONE
//   FILL_BYTE      : value written to every RAM location during CLEAR
// ---------------------------------------------------------------------------
package apf_pkg;

  // Loader sequencing states. CLEAR is only reachable when the clear
  // feature is compiled in, but the encoding is kept stable in both builds.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Erased-ROM pattern, so unloaded cartridge space reads like blank flash.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/cart_loader.sv
// ---------------------------------------------------------------------------
// cart_loader
//
// Purpose
//   Receives a cartridge image streamed from the HPS ioctl interface and
//   writes it into the write side of a dual-port cartridge RAM. While an
//   image is being loaded the CPU is held in reset; the reset is released a
//   fixed number of cycles after the download ends. An optional clear pass
//   fills the whole RAM with FILL_BYTE before the image arrives.
//
// Build option
//   CART_CLEAR_EN : when defined, every accepted download first clears the
//                   RAM (one byte per cycle) while stalling the HPS with
//                   ioctl_wait. When undefined, the clear logic is absent,
//                   a download goes straight to LOAD and ioctl_wait is 0.
//
// Parameters
//   addr_width_g  : RAM address width, RAM depth is 2**addr_width_g
//   data_width_g  : width of ioctl_dout / ram_d
//   index_g       : ioctl_index value that selects cartridge downloads
//   hold_cycles_g : cycles cpu_reset stays high after the download ends
//
// Ports
//   clk_sys        in  system clock (only clock)
//   reset_n        in  asynchronous active-low reset
//   ioctl_download in  HPS download active
//   ioctl_index    in  download target selector
//   ioctl_wr       in  one-cycle byte strobe
//   ioctl_addr     in  byte address of the strobed byte
//   ioctl_dout     in  byte data
//   ioctl_wait     out stall request to the HPS (only during CLEAR)
//   ram_we         out RAM write enable
//   ram_ad         out RAM write address
//   ram_d          out RAM write data
//   cpu_reset      out hold the CPU in reset
//   cart_loaded    out a non-empty image has been loaded
//   cart_size      out number of bytes covered by the image (highest addr+1)
//   load_err       out sticky error: out-of-range or dropped write
// ---------------------------------------------------------------------------
module cart_loader
  import apf_pkg::*;
#(
  parameter int         addr_width_g  = 14,
  parameter int         data_width_g  = 8,
  parameter logic [7:0] index_g       = 8'h01,
  parameter int         hold_cycles_g = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [26:0]             ioctl_addr,
  input  logic [data_width_g-1:0] ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    ram_we,
  output logic [addr_width_g-1:0] ram_ad,
  output logic [data_width_g-1:0] ram_d,
  output logic                    cpu_reset,
  output logic                    cart_loaded,
  output logic [addr_width_g:0]   cart_size,
  output logic                    load_err
);

  // The hold counter is loaded with hold_cycles_g-1 in DONE and counts down
  // in IDLE, so cpu_reset drops exactly hold_cycles_g cycles after DONE.
  localparam int HOLD_W = (hold_cycles_g > 2) ? $clog2(hold_cycles_g) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (hold_cycles_g > 1) ? HOLD_W'(hold_cycles_g - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  loader_state_t r_state;
  loader_state_t w_next;

  logic                    r_dl_prev;
  logic                    r_we;
  logic [addr_width_g-1:0] r_ad;
  logic [data_width_g-1:0] r_d;
  logic [addr_width_g:0]   r_size;
  logic                    r_loaded;
  logic                    r_err;
  logic                    r_cpu_reset;
  logic [HOLD_W-1:0]       r_hold;

  logic                    w_rise;
  logic                    w_fall;
  logic                    w_start;
  logic                    w_in_range;
  logic                    w_accept;
  logic                    w_reject;
  logic [addr_width_g:0]   w_addr_p1;

  // Download edge detection against last cycle's level.
  assign w_rise = ioctl_download & ~r_dl_prev;
  assign w_fall = ~ioctl_download & r_dl_prev;

  // Only a rising edge aimed at the cartridge index starts a load; starting
  // is only possible from IDLE (the hold period lives in IDLE too).
  assign w_start = (r_state == IDLE) && w_rise && (ioctl_index == index_g);

  // Address is in range when no bit at or above addr_width_g is set.
  assign w_in_range = ((ioctl_addr >> addr_width_g) == 27'd0);

  // A write is only taken while the download is still active, so its
  // one-cycle-late RAM pulse can never land in DONE.
  assign w_accept = (r_state == LOAD) && ioctl_wr && ioctl_download && w_in_range;

  assign w_addr_p1 = {1'b0, ioctl_addr[addr_width_g-1:0]} +
                     {{addr_width_g{1'b0}}, 1'b1};

`ifdef CART_CLEAR_EN
  localparam logic [addr_width_g-1:0] AD_ONE = addr_width_g'(1);

  logic [addr_width_g-1:0] r_clr_addr;
  logic                    w_clr_last;

  assign w_clr_last = &r_clr_addr;

  // Strobes while clearing cannot be stored, so they are flagged as errors.
  assign w_reject = ((r_state == LOAD) && ioctl_wr && !w_in_range) ||
                    ((r_state == CLEAR) && ioctl_wr);

  // Clear address walks 0..depth-1, one location per CLEAR cycle, and is
  // rewound at every new start so each clear pass begins at address 0.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_addr <= '0;
    end else if (w_start) begin
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + AD_ONE;
    end
  end

  // During CLEAR the RAM port is owned by the fill pass; otherwise it
  // carries the registered image write.
  assign ram_we     = r_we | (r_state == CLEAR);
  assign ram_ad     = (r_state == CLEAR) ? r_clr_addr : r_ad;
  assign ram_d      = (r_state == CLEAR) ? data_width_g'(FILL_BYTE) : r_d;
  assign ioctl_wait = (r_state == CLEAR);
`else
  assign w_reject = (r_state == LOAD) && ioctl_wr && !w_in_range;

  // Without the clear pass the RAM port only ever carries image writes
  // and the HPS is never stalled.
  assign ram_we     = r_we;
  assign ram_ad     = r_ad;
  assign ram_d      = r_d;
  assign ioctl_wait = 1'b0;
`endif

  // State register plus the download level history used for edge detect.
  // Reset clears both, so a download in flight is simply forgotten.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_dl_prev <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dl_prev <= ioctl_download;
    end
  end

  // Next-state logic. A falling download edge ends LOAD, and also aborts an
  // unfinished CLEAR; in that case no image byte was ever accepted, so the
  // size is still the zero set at start and DONE reports an empty cart.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
`ifdef CART_CLEAR_EN
          w_next = CLEAR;
`else
          w_next = LOAD;
`endif
        end
      end
      CLEAR: begin
`ifdef CART_CLEAR_EN
        if (w_fall) begin
          w_next = DONE;
        end else if (w_clr_last) begin
          w_next = LOAD;
        end
`else
        w_next = IDLE;
`endif
      end
      LOAD: begin
        if (w_fall) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Image write path: the strobed byte and address are registered so the
  // RAM sees exactly one write the cycle after each accepted strobe.
  // cart_size only grows, so bytes arriving out of order never shrink it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_ad   <= '0;
      r_d    <= '0;
      r_size <= '0;
    end else begin
      r_we <= w_accept;
      if (w_start) begin
        r_size <= '0;
      end else if (w_accept) begin
        r_ad <= ioctl_addr[addr_width_g-1:0];
        r_d  <= ioctl_dout;
        if (w_addr_p1 > r_size) begin
          r_size <= w_addr_p1;
        end
      end
    end
  end

  // Status flags and the CPU reset hold. A start re-arms everything and
  // cancels any hold still counting down; DONE latches cart_loaded and
  // launches the hold countdown, which then runs while the FSM idles.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_hold      <= '0;
    end else if (w_start) begin
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_hold      <= '0;
    end else begin
      if (w_reject) begin
        r_err <= 1'b1;
      end
      if (r_state == DONE) begin
        r_loaded <= (r_size != '0);
        r_hold   <= HOLD_LOAD;
        if (hold_cycles_g <= 1) begin
          r_cpu_reset <= 1'b0;
        end
      end else if ((r_state == IDLE) && (r_hold != '0)) begin
        r_hold <= r_hold - HOLD_ONE;
        if (r_hold == HOLD_ONE) begin
          r_cpu_reset <= 1'b0;
        end
      end
    end
  end

  assign cpu_reset   = r_cpu_reset;
  assign cart_loaded = r_loaded;
  assign cart_size   = r_size;
  assign load_err    = r_err;

endmodule

// File: tb/tb_cart_loader.sv
// ---------------------------------------------------------------------------
// tb_cart_loader
//
// Directed download sequences with randomized image bytes, checked against
// a behavioural picture of the cartridge RAM and loader status kept here.
// Honours CART_CLEAR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cart_loader;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int HOLD  = 16;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'h00;
  logic          ioctl_wr = 1'b0;
  logic [26:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic          ram_we;
  logic [AW-1:0] ram_ad;
  logic [7:0]    ram_d;
  logic          cpu_reset;
  logic          cart_loaded;
  logic [AW:0]   cart_size;
  logic          load_err;

  always #5 clk_sys = ~clk_sys;

  cart_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ram_we         (ram_we),
    .ram_ad         (ram_ad),
    .ram_d          (ram_d),
    .cpu_reset      (cpu_reset),
    .cart_loaded    (cart_loaded),
    .cart_size      (cart_size),
    .load_err       (load_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference picture of what the RAM and status outputs should be.
  logic [7:0] refMem [DEPTH];
  int         expSize = 0;
  logic       expErr  = 1'b0;
  int         expWe   = 0;
  int         expWait = 0;

  // What the RAM actually received, captured from the write port.
  logic [7:0] dutMem [DEPTH];
  int         weCount   = 0;
  int         waitCount = 0;

  always @(posedge clk_sys) begin
    if (ram_we === 1'b1) begin
      dutMem[ram_ad] = ram_d;
      weCount = weCount + 1;
    end
    if (ioctl_wait === 1'b1) begin
      waitCount = waitCount + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // RAM fill done by a clear pass over addresses 0..last.
  task automatic modelClear(input int last);
    for (int a = 0; a <= last; a++) begin
      refMem[a] = 8'hFF;
    end
    expWe   += last + 1;
    expWait += last + 1;
  endtask

  // One HPS byte strobe during LOAD, with the resulting RAM pulse checked
  // one cycle later and its single-cycle width checked after that.
  task automatic applyStimulus(input logic [26:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    checkOutput("we_latency", ram_we, 0);
    tick();
    ioctl_wr = 1'b0;
    if (a < DEPTH) begin
      refMem[a] = d;
      expWe++;
      if (int'(a) + 1 > expSize) expSize = int'(a) + 1;
      checkOutput("we_pulse", ram_we, 1);
      checkOutput("we_addr", ram_ad, a[AW-1:0]);
      checkOutput("we_data", ram_d, d);
    end else begin
      expErr = 1'b1;
      checkOutput("oor_no_we", ram_we, 0);
    end
    checkOutput("size", cart_size, expSize);
    checkOutput("err", load_err, expErr);
    tick();
    checkOutput("we_single", ram_we, 0);
  endtask

  task automatic startDownload();
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    tick();
    expSize = 0;
    expErr  = 1'b0;
    checkOutput("start_cpu_reset", cpu_reset, 1);
    checkOutput("start_loaded", cart_loaded, 0);
    checkOutput("start_size", cart_size, 0);
    checkOutput("start_err", load_err, 0);
`ifdef CART_CLEAR_EN
    checkOutput("start_wait", ioctl_wait, 1);
`else
    checkOutput("start_wait", ioctl_wait, 0);
`endif
  endtask

  // Ends a download: checks the DONE cycle and the first IDLE cycle.
  task automatic dropDownload(input logic expLoaded);
    ioctl_download = 1'b0;
    tick();
    checkOutput("done_we", ram_we, 0);
    checkOutput("done_wait", ioctl_wait, 0);
    checkOutput("done_size", cart_size, expSize);
    checkOutput("done_cpu_reset", cpu_reset, 1);
    tick();
    checkOutput("loaded", cart_loaded, expLoaded);
    checkOutput("idle_we", ram_we, 0);
  endtask

  // Cycles from the DONE cycle until cpu_reset is first seen low.
  task automatic measureHold(input int already);
    int n = already;
    while (cpu_reset === 1'b1 && n < HOLD + 50) begin
      tick();
      n++;
    end
    checkOutput("hold_len", n, HOLD);
  endtask

`ifdef CART_CLEAR_EN
  task automatic waitClear();
    int n   = 0;
    int bad = 0;
    while (ioctl_wait === 1'b1 && n < DEPTH + 100) begin
      if (ram_we !== 1'b1 || ram_d !== 8'hFF || ram_ad !== AW'(n)) bad++;
      n++;
      tick();
    end
    checkOutput("clear_len", n, DEPTH);
    checkOutput("clear_writes_bad", bad, 0);
    checkOutput("clear_wait_low", ioctl_wait, 0);
    modelClear(DEPTH - 1);
  endtask
`endif

  initial begin
    int n;
    int bad;
    logic [26:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = 8'h00;
      dutMem[i] = 8'h00;
    end

    // Reset state.
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_cpu_reset", cpu_reset, 0);
    checkOutput("rst_we", ram_we, 0);
    checkOutput("rst_wait", ioctl_wait, 0);
    checkOutput("rst_size", cart_size, 0);
    checkOutput("rst_loaded", cart_loaded, 0);
    checkOutput("rst_err", load_err, 0);
    reset_n = 1'b1;
    tick();

    // A download for another target must be ignored entirely.
    ioctl_index    = 8'h00;
    ioctl_download = 1'b1;
    tick();
    tick();
    ioctl_addr = 27'd3;
    ioctl_dout = 8'h99;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    checkOutput("idx0_cpu_reset", cpu_reset, 0);
    checkOutput("idx0_wait", ioctl_wait, 0);
    checkOutput("idx0_we", ram_we, 0);
    checkOutput("idx0_err", load_err, 0);
    ioctl_download = 1'b0;
    tick();

    // Download 1: fixed image, overwrite, out-of-order and out-of-range.
    startDownload();
`ifdef CART_CLEAR_EN
    waitClear();
`endif
    applyStimulus(27'd0, 8'h11);
    applyStimulus(27'd0, 8'hA5);
    applyStimulus(27'd1, 8'h5A);
    applyStimulus(27'd2, 8'h3C);
    applyStimulus(27'd3, 8'hC3);
    applyStimulus(27'd1, 8'h5A);
    applyStimulus(27'd16384, 8'h77);
    dropDownload(1'b1);
    checkOutput("d1_size", cart_size, 4);
    checkOutput("d1_err_sticky", load_err, 1);
    measureHold(1);

    // Download 2: random bytes, some beyond the RAM.
    startDownload();
`ifdef CART_CLEAR_EN
    waitClear();
`endif
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = 27'(DEPTH + $urandom_range(0, 5000));
      end else begin
        a = 27'($urandom_range(0, DEPTH - 1));
      end
      applyStimulus(a, 8'($urandom_range(0, 255)));
    end
    dropDownload(expSize != 0);

    // Download 3 starts during the hold: cpu_reset must stay high and the
    // hold must restart from this download's DONE.
    for (int i = 0; i < 4; i++) tick();
    checkOutput("hold_mid", cpu_reset, 1);
    startDownload();
`ifdef CART_CLEAR_EN
    n = 0;
    while (ram_ad !== 14'd10 && n < 200) begin
      tick();
      n++;
    end
    ioctl_addr = 27'd5;
    ioctl_dout = 8'h42;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    expErr   = 1'b1;
    checkOutput("clear_wr_err", load_err, 1);
    checkOutput("clear_wr_data", ram_d, 8'hFF);
    checkOutput("clear_wr_addr", ram_ad, 14'd11);
    n = 0;
    while (ram_ad !== 14'd100 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("abort_reached", ram_ad, 14'd100);
    modelClear(100);
`else
    tick();
    tick();
`endif
    dropDownload(1'b0);
    checkOutput("d3_size", cart_size, 0);
    checkOutput("d3_err", load_err, expErr);
    measureHold(1);

    // Download 4: reset asserted mid-LOAD.
    startDownload();
`ifdef CART_CLEAR_EN
    waitClear();
`endif
    applyStimulus(27'd7, 8'($urandom_range(0, 255)));
    ioctl_addr = 27'd8;
    ioctl_dout = 8'h5E;
    ioctl_wr   = 1'b1;
    reset_n    = 1'b0;
    #1;
    checkOutput("arst_cpu_reset", cpu_reset, 0);
    checkOutput("arst_we", ram_we, 0);
    checkOutput("arst_ad", ram_ad, 0);
    checkOutput("arst_d", ram_d, 0);
    checkOutput("arst_size", cart_size, 0);
    checkOutput("arst_loaded", cart_loaded, 0);
    checkOutput("arst_err", load_err, 0);
    checkOutput("arst_wait", ioctl_wait, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ram_we !== 1'b0) bad++;
    end
    checkOutput("arst_no_we", bad, 0);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    reset_n        = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_rst_cpu_reset", cpu_reset, 0);
    checkOutput("post_rst_we", ram_we, 0);

    // Whole-run totals against the reference picture.
    tick();
    checkOutput("we_count", weCount, expWe);
    checkOutput("wait_cycles", waitCount, expWait);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dutMem[i] !== refMem[i]) bad++;
    end
    checkOutput("ram_contents_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 SHALL have parameter addr_width_g, default 14: RAM address width; depth is 2**addr_width_g.
REQ-002 SHALL have parameter data_width_g, default 8: byte width of ioctl_dout and ram_d.
REQ-003 SHALL have parameter index_g, default 8'h01: ioctl_index value that selects cartridge downloads.
REQ-004 SHALL have parameter hold_cycles_g, default 16: cycles cpu_reset stays high after download end.
REQ-005 SHALL have ports, in order: clk_sys in 1, system clock (sole clock); reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ioctl_download in 1 (HPS download active); ioctl_index in 8 (download target); ioctl_wr in 1 (one-cycle byte strobe); ioctl_addr in 27 (byte address); ioctl_dout in data_width_g (byte data).
REQ-007 SHALL have ioctl_wait out 1, request for the HPS to stall.
REQ-008 SHALL have ram_we out 1, ram_ad out addr_width_g and ram_d out data_width_g, driving the write side of a dpram port.
REQ-009 SHALL have cpu_reset out 1 (hold CPU in reset); cart_loaded out 1 (valid image present); cart_size out addr_width_g+1 (bytes loaded); load_err out 1 (sticky error).

Function
REQ-010 SHALL implement states IDLE, CLEAR, LOAD and DONE.
REQ-011 IDLE -> start on a rising edge of ioctl_download sampled while ioctl_index == index_g; a rising edge with any other index SHALL be ignored.
REQ-012 At start: cpu_reset=1, cart_loaded=0, cart_size=0, load_err=0; next state is CLEAR or LOAD per REQ-023/024.
REQ-013 CLEAR: one write per cycle, ram_we=1, ram_d=FILL_BYTE, ram_ad counting 0 .. depth-1; ioctl_wait=1 throughout; after address depth-1, go to LOAD with ioctl_wait=0 on the next cycle.
REQ-014 LOAD: ioctl_wr with ioctl_addr < depth SHALL produce exactly one ram_we pulse on the following cycle (latency 1), with ram_ad=ioctl_addr[addr_width_g-1:0] and ram_d=ioctl_dout as registered at the strobe.
REQ-015 LOAD: cart_size SHALL update to max(cart_size, ioctl_addr+1) on each accepted write; bytes written out of order SHALL not shrink it.
REQ-016 LOAD: ioctl_wr with ioctl_addr >= depth SHALL not write, SHALL set load_err, and SHALL leave cart_size unchanged.
REQ-017 An ioctl_wr arriving in CLEAR SHALL be dropped and SHALL set load_err.
REQ-018 A falling edge of ioctl_download in LOAD -> DONE; in CLEAR it SHALL abort the clear -> DONE with cart_size=0.
REQ-019 DONE lasts one cycle: cart_loaded=1 if cart_size != 0, else 0; then IDLE, and the hold counter starts.
REQ-020 cpu_reset SHALL fall exactly hold_cycles_g cycles after DONE; a new start during the hold SHALL re-assert it and clear the counter.
REQ-021 ram_we SHALL be 0 in IDLE and DONE; ioctl_wait SHALL be 0 outside CLEAR.

Reset
REQ-022 On reset_n low, all outputs SHALL go to 0 asynchronously (cpu_reset=0, cart_size=0), state IDLE, counters 0, edge-detect history 0; a download in progress SHALL be abandoned and no further writes issued.

Configuration
REQ-023 With CART_CLEAR_EN defined, start SHALL enter CLEAR per REQ-013.
REQ-024 Without CART_CLEAR_EN, start SHALL enter LOAD directly, CLEAR logic SHALL be absent, ioctl_wait SHALL be constant 0, and REQ-017 does not apply.

Structure
REQ-025 Shared package apf_pkg SHALL hold the loader state enum typedef and constant FILL_BYTE = 8'hFF.
REQ-026 No sub-module: edge detect, address counter and hold counter SHALL live in cart_loader.

Verification
REQ-027 Defaults with CART_CLEAR_EN: download rises with index 1 -> ioctl_wait=1 for 16384 cycles, 16384 writes of 8'hFF to 0..16383, then wait=0.
REQ-028 Write 4 bytes A5,5A,3C,C3 at addr 0-3, then drop download -> RAM holds them one cycle after each strobe; cart_size=4, cart_loaded=1; cpu_reset falls 16 cycles after DONE.
REQ-029 Write addr 16384 data 77 -> no ram_we, load_err=1, cart_size unchanged.
REQ-030 Download with index 0 -> no state change, no ram_we, cpu_reset stays 0.
REQ-031 Drop download at clear address 100 -> DONE, cart_size=0, cart_loaded=0; assert reset_n=0 mid-LOAD -> all outputs 0 immediately, no ram_we after.
REQ-032 Without CART_CLEAR_EN: first strobe at addr 0 data 11 -> ram_we on the next cycle, ioctl_wait never 1.
